// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame reader.
// Holds the display timing constants, the framebuffer geometry, the pixel
// type, the clear-engine state encoding and the framebuffer address helper.
package vga_pkg;

    // Display timing; must match the downstream VGA timing driver bit for bit.
    localparam int H_SYNC  = 96;
    localparam int H_BACK  = 48;
    localparam int H_DATA  = 640;
    localparam int H_CYCLE = 800;
    localparam int C_SYNC  = 2;
    localparam int C_BACK  = 29;
    localparam int C_DATA  = 480;
    localparam int C_CYCLE = 521;

    // First active column / row of the visible window.
    localparam int HA = H_SYNC + H_BACK;
    localparam int VA = C_SYNC + C_BACK;

    // Fetch lookahead; equals the read latency (RAM register + output register).
    localparam int LEAD = 2;

    // Framebuffer geometry, shown at 4x scale.
    localparam int FB_W     = 160;
    localparam int FB_H     = 120;
    localparam int FB_DEPTH = FB_W * FB_H;
    localparam int ADDR_W   = 15;
    localparam int CNT_W    = 10;

    typedef logic [11:0]       rgb444_t;
    typedef logic [ADDR_W-1:0] fb_addr_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    // row*160 + col built from shifts so no multiplier is inferred.
    function automatic fb_addr_t fb_addr(input logic [6:0] row, input logic [7:0] col);
        fb_addr_t row_w;
        row_w = {8'b0000_0000, row};
        return (row_w << 7) + (row_w << 5) + {7'b000_0000, col};
    endfunction

endpackage

// File: rtl/vga_fb_ram.sv
// Simple dual-port 19200 x 12 framebuffer RAM.
// One synchronous write port, one independent read port with a registered
// output (1-cycle latency). A read of the address being written in the same
// cycle returns the old contents. Contents are never reset.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address (must be < FB_DEPTH when we_i is high)
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : registered read data
module vga_fb_ram
    import vga_pkg::*;
(
    input  logic     clk_i,
    input  logic     we_i,
    input  fb_addr_t waddr_i,
    input  rgb444_t  wdata_i,
    input  fb_addr_t raddr_i,
    output rgb444_t  rdata_o
);

    rgb444_t mem [FB_DEPTH];

    // Write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Registered read port.
    always_ff @(posedge clk_i) begin
        rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/vga_frame_reader.sv
// Pixel source for the VGA timing driver.
// Runs timing counters in lockstep with the driver (same clock, same reset),
// fetches the 160x120 framebuffer at 4x scale LEAD cycles ahead so the pixel
// for driver position (h_cnt, c_cnt) is on color_data in that same cycle.
// Provides a CPU write port, a bulk-clear engine and frame-sync status.
//   vga_clk     : pixel clock
//   sys_rst     : asynchronous reset, active-low
//   wr_en       : pixel write request
//   wr_addr     : framebuffer address y*160+x (>= 19200 is dropped)
//   wr_data     : RGB444 pixel
//   wr_ready    : write accepted when high together with wr_en
//   clear_req   : start bulk clear (single-cycle pulse)
//   clear_color : fill value, sampled with clear_req
//   clear_busy  : clear in progress
//   frame_start : one-cycle pulse at h_cnt=0, c_cnt=0
//   vblank      : c_cnt outside the active rows
//   color_data  : pixel to the VGA driver
module vga_frame_reader #(
    parameter int H_SYNC  = vga_pkg::H_SYNC,
    parameter int H_BACK  = vga_pkg::H_BACK,
    parameter int H_DATA  = vga_pkg::H_DATA,
    parameter int H_CYCLE = vga_pkg::H_CYCLE,
    parameter int C_SYNC  = vga_pkg::C_SYNC,
    parameter int C_BACK  = vga_pkg::C_BACK,
    parameter int C_DATA  = vga_pkg::C_DATA,
    parameter int C_CYCLE = vga_pkg::C_CYCLE,
    parameter int LEAD    = vga_pkg::LEAD
) (
    input  logic        vga_clk,
    input  logic        sys_rst,
    input  logic        wr_en,
    input  logic [14:0] wr_addr,
    input  logic [11:0] wr_data,
    output logic        wr_ready,
    input  logic        clear_req,
    input  logic [11:0] clear_color,
    output logic        clear_busy,
    output logic        frame_start,
    output logic        vblank,
    output logic [11:0] color_data
);
    import vga_pkg::*;

    localparam int ACT_H0 = H_SYNC + H_BACK;
    localparam int ACT_V0 = C_SYNC + C_BACK;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_CYCLE - 1);
    localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(C_CYCLE - 1);
    localparam logic [CNT_W-1:0] V_FIRST  = CNT_W'(ACT_V0);
    localparam logic [CNT_W-1:0] V_END    = CNT_W'(ACT_V0 + C_DATA);
    localparam logic [CNT_W:0]   FX_FIRST = (CNT_W+1)'(ACT_H0);
    localparam logic [CNT_W:0]   FX_END   = (CNT_W+1)'(ACT_H0 + H_DATA);
    localparam logic [CNT_W:0]   LEAD_X   = (CNT_W+1)'(LEAD);
    localparam fb_addr_t         FB_END   = ADDR_W'(FB_DEPTH);
    localparam fb_addr_t         CLR_LAST = ADDR_W'(FB_DEPTH - 1);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] c_cnt_q, c_cnt_d;
    logic             frame_start_q, frame_start_d;
    logic             vblank_q, vblank_d;

    logic [CNT_W:0]   hx_s;
    logic [CNT_W:0]   fx_s;
    logic [CNT_W-1:0] py_s;
    logic [7:0]       fetch_col_s;
    logic [6:0]       fetch_row_s;
    logic             fetch_valid_s;
    fb_addr_t         fetch_addr_s;
    logic             valid_q;
    rgb444_t          ram_rdata_s;
    rgb444_t          color_q;

    clr_state_e       state_q, state_d;
    fb_addr_t         clr_addr_q, clr_addr_d;
    rgb444_t          clr_color_q, clr_color_d;
    logic             busy_q;
    logic             wr_ready_q;
    logic             ram_we_s;
    fb_addr_t         ram_waddr_s;
    rgb444_t          ram_wdata_s;

    // Next-state of the timing counters and the early-decoded sync status.
    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        c_cnt_d = c_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = 10'd0;
            if (c_cnt_q == C_LAST) begin
                c_cnt_d = 10'd0;
            end else begin
                c_cnt_d = c_cnt_q + 10'd1;
            end
        end else begin
            c_cnt_d = c_cnt_q;
        end
        // Decoded from the next counter values so the registered flags line up
        // with the counters they describe.
        frame_start_d = (h_cnt_d == 10'd0) && (c_cnt_d == 10'd0);
        vblank_d      = !((c_cnt_d >= V_FIRST) && (c_cnt_d < V_END));
    end

    // Fetch address for the pixel LEAD cycles ahead on the current row.
    always_comb begin
        hx_s          = {1'b0, h_cnt_q} + LEAD_X;
        fx_s          = hx_s - FX_FIRST;
        py_s          = c_cnt_q - V_FIRST;
        fetch_valid_s = (hx_s >= FX_FIRST) && (hx_s < FX_END) &&
                        (c_cnt_q >= V_FIRST) && (c_cnt_q < V_END);
        fetch_col_s   = 8'(fx_s >> 2);
        fetch_row_s   = 7'(py_s >> 2);
        fetch_addr_s  = fb_addr(fetch_row_s, fetch_col_s);
    end

    // Clear FSM next state and arbitration of the single RAM write port.
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        clr_color_d = clr_color_q;
        ram_we_s    = 1'b0;
        ram_waddr_s = wr_addr;
        ram_wdata_s = wr_data;
        case (state_q)
            IDLE: begin
                // Out-of-range CPU writes are accepted but never reach the RAM.
                if (wr_en && wr_ready_q && (wr_addr < FB_END)) begin
                    ram_we_s = 1'b1;
                end else begin
                    ram_we_s = 1'b0;
                end
                if (clear_req) begin
                    state_d     = CLEAR;
                    clr_addr_d  = 15'd0;
                    clr_color_d = clear_color;
                end else begin
                    state_d     = IDLE;
                end
            end
            CLEAR: begin
                ram_we_s    = 1'b1;
                ram_waddr_s = clr_addr_q;
                ram_wdata_s = clr_color_q;
                if (clr_addr_q == CLR_LAST) begin
                    state_d    = IDLE;
                    clr_addr_d = 15'd0;
                end else begin
                    state_d    = CLEAR;
                    clr_addr_d = clr_addr_q + 15'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Timing counters, sync flags, read pipeline and clear engine registers.
    always_ff @(posedge vga_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            h_cnt_q       <= 10'd0;
            c_cnt_q       <= 10'd0;
            frame_start_q <= 1'b0;
            vblank_q      <= 1'b1;
            valid_q       <= 1'b0;
            color_q       <= 12'h000;
            state_q       <= IDLE;
            clr_addr_q    <= 15'd0;
            clr_color_q   <= 12'h000;
            busy_q        <= 1'b0;
            wr_ready_q    <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            c_cnt_q       <= c_cnt_d;
            frame_start_q <= frame_start_d;
            vblank_q      <= vblank_d;
            valid_q       <= fetch_valid_s;
            // Invalid fetches read arbitrary cells; blank them here.
            color_q       <= valid_q ? ram_rdata_s : 12'h000;
            state_q       <= state_d;
            clr_addr_q    <= clr_addr_d;
            clr_color_q   <= clr_color_d;
            busy_q        <= (state_d == CLEAR);
            wr_ready_q    <= (state_d == IDLE);
        end
    end

    vga_fb_ram u_ram (
        .clk_i   (vga_clk),
        .we_i    (ram_we_s),
        .waddr_i (ram_waddr_s),
        .wdata_i (ram_wdata_s),
        .raddr_i (fetch_addr_s),
        .rdata_o (ram_rdata_s)
    );

    assign wr_ready    = wr_ready_q;
    assign clear_busy  = busy_q;
    assign frame_start = frame_start_q;
    assign vblank      = vblank_q;
    assign color_data  = color_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Self-checking bench for vga_frame_reader: a full-timing instance exercised
// with writes, clears and a mid-clear reset, plus a reduced-timing instance
// whose short frame makes the frame_start period observable.
module tb_vga_frame_reader;
    import vga_pkg::*;

    logic        vga_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [14:0] wr_addr = 15'd0;
    logic [11:0] wr_data = 12'h000;
    logic        clear_req = 1'b0;
    logic [11:0] clear_color = 12'h000;
    logic        wr_ready, clear_busy, frame_start, vblank;
    logic [11:0] color_data;
    logic        s_wr_ready, s_busy, s_fs, s_vb;
    logic [11:0] s_color;

    always #5 vga_clk = ~vga_clk;

    vga_frame_reader dut (
        .vga_clk(vga_clk), .sys_rst(sys_rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(wr_ready), .clear_req(clear_req),
        .clear_color(clear_color), .clear_busy(clear_busy), .frame_start(frame_start),
        .vblank(vblank), .color_data(color_data)
    );

    // Reduced timing: 32 pixels x 16 lines, active h 8..23, rows 3..10.
    vga_frame_reader #(
        .H_SYNC(4), .H_BACK(4), .H_DATA(16), .H_CYCLE(32),
        .C_SYNC(1), .C_BACK(2), .C_DATA(8), .C_CYCLE(16), .LEAD(2)
    ) dut_s (
        .vga_clk(vga_clk), .sys_rst(sys_rst), .wr_en(1'b0), .wr_addr(15'd0),
        .wr_data(12'h000), .wr_ready(s_wr_ready), .clear_req(1'b0),
        .clear_color(12'h000), .clear_busy(s_busy), .frame_start(s_fs),
        .vblank(s_vb), .color_data(s_color)
    );

    int n_cmp = 0;
    int n_err = 0;
    int g_ticks = 0;
    int bh = 0, bc = 0, sh = 0, sc = 0;
    bit m_clear = 1'b0;
    bit m_ready = 1'b0;
    int m_clr_addr = 0;
    logic [11:0] m_ccol = 12'h000;
    bit chk_color = 1'b1;
    logic [11:0] fb [FB_DEPTH];

    typedef struct {
        int          h;
        int          c;
        logic [11:0] col;
        logic        vb;
    } vec_t;
    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (h=%0d c=%0d t=%0t)", name, act, exp, bh, bc, $time);
        end
    endtask

    function automatic logic [11:0] exp_color();
        if (bh >= 144 && bh < 784 && bc >= 31 && bc < 511)
            return fb[((bc - 31) / 4) * 160 + (bh - 144) / 4];
        return 12'h000;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_color"}, color_data, 12'h000);
        check({tag, "_busy"}, clear_busy, 1'b0);
        check({tag, "_ready"}, wr_ready, 1'b0);
        check({tag, "_fs"}, frame_start, 1'b0);
        check({tag, "_vblank"}, vblank, 1'b1);
    endtask

    // One clock: apply the reference model for the edge, then compare outputs.
    task automatic tick();
        @(posedge vga_clk);
        #1;
        if (m_clear) begin
            fb[m_clr_addr] = m_ccol;
            if (m_clr_addr == FB_DEPTH - 1) m_clear = 1'b0;
            else m_clr_addr++;
        end else begin
            if (wr_en && m_ready && wr_addr < 15'd19200) fb[wr_addr] = wr_data;
            if (clear_req) begin
                m_clear = 1'b1;
                m_clr_addr = 0;
                m_ccol = clear_color;
            end
        end
        m_ready = !m_clear;
        bh++;
        if (bh == 800) begin bh = 0; bc = (bc == 520) ? 0 : bc + 1; end
        sh++;
        if (sh == 32) begin sh = 0; sc = (sc == 15) ? 0 : sc + 1; end
        g_ticks++;
        check("clear_busy", clear_busy, m_clear);
        check("wr_ready", wr_ready, m_ready);
        check("frame_start", frame_start, (bh == 0 && bc == 0));
        check("vblank", vblank, !(bc >= 31 && bc < 511));
        if (chk_color) check("color_data", color_data, exp_color());
        if (g_ticks < 1200) begin
            check("s_frame_start", s_fs, (sh == 0 && sc == 0));
            check("s_vblank", s_vb, !(sc >= 3 && sc < 11));
            check("s_busy", s_busy, 1'b0);
            check("s_ready", s_wr_ready, 1'b1);
            if (!(sh >= 8 && sh < 24 && sc >= 3 && sc < 11)) check("s_color_blank", s_color, 12'h000);
        end
    endtask

    task automatic cpu_write(input logic [14:0] a, input logic [11:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Runs a clear already started; returns the number of busy cycles seen.
    task automatic run_clear(output int cnt, input logic [11:0] retrig);
        cnt = 0;
        while (clear_busy && cnt < 20000) begin
            wr_en = (cnt == 100);
            wr_addr = 15'd5; wr_data = 12'h123;
            clear_req = (cnt == 50);
            clear_color = retrig;
            tick();
            cnt++;
        end
        wr_en = 1'b0; clear_req = 1'b0;
    endtask

    task automatic run_until(input int h, input int c, input string name);
        int guard;
        guard = 0;
        while (!(bh == h && bc == c) && guard < 60000) begin tick(); guard++; end
        if (guard >= 60000) begin
            n_cmp++; n_err++;
            $display("FAIL %s_timeout: position h=%0d c=%0d not reached", name, h, c);
        end
    endtask

    initial begin
        int cnt;
        int bad_new, bad_old;
        for (int i = 0; i < FB_DEPTH; i++) fb[i] = 12'h000;

        vecs[0]  = '{144,  30, 12'h000, 1'b1};
        vecs[1]  = '{143,  31, 12'h000, 1'b0};
        vecs[2]  = '{144,  31, 12'hF00, 1'b0};
        vecs[3]  = '{147,  31, 12'hF00, 1'b0};
        vecs[4]  = '{148,  31, 12'h000, 1'b0};
        vecs[5]  = '{164,  31, 12'h000, 1'b0};
        vecs[6]  = '{779,  31, 12'h000, 1'b0};
        vecs[7]  = '{780,  31, 12'h0F0, 1'b0};
        vecs[8]  = '{784,  31, 12'h000, 1'b0};
        vecs[9]  = '{144,  34, 12'hF00, 1'b0};
        vecs[10] = '{783,  34, 12'h0F0, 1'b0};
        vecs[11] = '{144,  35, 12'h000, 1'b0};

        // Reset state.
        repeat (3) @(posedge vga_clk);
        #1;
        check_reset_outputs("reset");
        check("reset_s_vblank", s_vb, 1'b1);
        @(negedge vga_clk);
        sys_rst = 1'b1;
        tick();
        tick();

        // Clear to black; a write during the clear must not land.
        clear_req = 1'b1; clear_color = 12'h000;
        tick();
        clear_req = 1'b0;
        run_clear(cnt, 12'h000);
        check("clear0_len", cnt, 19200);

        // Pattern writes, including two out-of-range addresses.
        cpu_write(15'd0, 12'hF00);
        cpu_write(15'd159, 12'h0F0);
        cpu_write(15'd19199, 12'h00F);
        cpu_write(15'd19200, 12'h555);
        cpu_write(15'd32767, 12'h555);
        check("mem0", dut.u_ram.mem[0], 12'hF00);
        check("mem19199", dut.u_ram.mem[19199], 12'h00F);
        check("mem5_blocked", dut.u_ram.mem[5], 12'h000);

        // Directed display probes.
        for (int i = 0; i < 12; i++) begin
            run_until(vecs[i].h, vecs[i].c, "vec");
            check($sformatf("vec%0d_color", i), color_data, vecs[i].col);
            check($sformatf("vec%0d_vblank", i), vblank, vecs[i].vb);
        end

        // Write and clear_req in the same idle cycle, then a clear during display.
        run_until(0, 37, "pre_clear");
        chk_color = 1'b0;
        wr_en = 1'b1; wr_addr = 15'd2; wr_data = 12'h777;
        clear_req = 1'b1; clear_color = 12'hABC;
        tick();
        wr_en = 1'b0; clear_req = 1'b0;
        check("mem2_same_cycle", dut.u_ram.mem[2], 12'h777);
        run_clear(cnt, 12'h111);
        check("clear_abc_len", cnt, 19200);
        tick();
        tick();
        chk_color = 1'b1;
        bad_new = 0;
        for (int i = 0; i < FB_DEPTH; i++) if (dut.u_ram.mem[i] !== 12'hABC) bad_new++;
        check("clear_abc_cells_bad", bad_new, 0);
        run_until(0, 66, "abc_rows");

        // Reset in the middle of a clear.
        chk_color = 1'b0;
        clear_req = 1'b1; clear_color = 12'h5A5;
        tick();
        clear_req = 1'b0;
        repeat (5000) tick();
        sys_rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        m_clear = 1'b0; m_ready = 1'b0;
        bh = 0; bc = 0; sh = 0; sc = 0;
        repeat (3) @(posedge vga_clk);
        #1;
        check("midrst_hold_busy", clear_busy, 1'b0);
        @(negedge vga_clk);
        sys_rst = 1'b1;
        chk_color = 1'b1;
        repeat (40) tick();
        bad_new = 0;
        bad_old = 0;
        for (int i = 0; i < 5000; i++) if (dut.u_ram.mem[i] !== 12'h5A5) bad_new++;
        for (int i = 5000; i < FB_DEPTH; i++) if (dut.u_ram.mem[i] !== 12'hABC) bad_old++;
        check("partial_new_bad", bad_new, 0);
        check("partial_old_bad", bad_old, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
